// File: rtl/grn_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// grn_ctrl_pkg
// Shared types and constants for the Boolean-network attractor controller.
//   state_t   : controller FSM states. The MU_* states are reachable only when
//               the design is built with GRN_TRANSIENT_EN defined.
//   CNT_W_DEF : default width of the step, period and transient counters.
// -----------------------------------------------------------------------------
package grn_ctrl_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    PERIOD,
    MU_LOAD,
    MU_ADV,
    MU_STEP,
    DONE
  } state_t;

endpackage

// File: rtl/grn_step_counter.sv
// -----------------------------------------------------------------------------
// grn_step_counter
// Saturating up-counter used for the step, period and transient counts.
// It stops at MAX_STEPS and never wraps.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-low reset
//   i_clr      : clear to zero (takes priority over i_inc)
//   i_inc      : increment by one unless already at MAX_STEPS
//   o_cnt      : current count
//   o_at_limit : count equals MAX_STEPS
// -----------------------------------------------------------------------------
module grn_step_counter
  import grn_ctrl_pkg::*;
#(
  parameter int unsigned      CNT_W     = CNT_W_DEF,
  parameter logic [CNT_W-1:0] MAX_STEPS = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_at_limit
);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, whatever order the blocks run in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_STEPS)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt      = r_cnt;
  assign o_at_limit = (r_cnt == MAX_STEPS);

endmodule

// File: rtl/grn_attractor_ctrl.sv
// -----------------------------------------------------------------------------
// grn_attractor_ctrl
// Finds the attractor of a synchronous Boolean network using Floyd's
// tortoise-and-hare search. The nodes keep two trajectories: s1 (hare) moves
// on every start_s1, s0 (tortoise) moves on every second start_s0. The
// controller reports the attractor state met, the cycle length (period) and,
// when built with GRN_TRANSIENT_EN defined, the transient length before the
// cycle is entered. Without that macro the MU_* states are absent and
// transient is tied to zero.
// Ports:
//   clk, rst          : clock, synchronous active-low reset
//   start, init_vec   : begin a search from init_vec (sampled in IDLE only)
//   s0_vec, s1_vec    : slow / fast trajectory states from the nodes
//   reset_nos         : load init_state into all nodes
//   init_state        : captured init_vec
//   start_s0/start_s1 : node step enables
//   busy, done        : search in progress / one-cycle completion pulse
//   timeout           : a counter hit MAX_STEPS without a match
//   period, transient : cycle and tail lengths
//   attractor         : s0 state at the first Floyd match
// -----------------------------------------------------------------------------
module grn_attractor_ctrl
  import grn_ctrl_pkg::*;
#(
  parameter int unsigned      NUM_NODES = 8,
  parameter int unsigned      CNT_W     = CNT_W_DEF,
  parameter logic [CNT_W-1:0] MAX_STEPS = CNT_W'(16'hFFFF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_NODES-1:0] init_vec,
  input  logic [NUM_NODES-1:0] s0_vec,
  input  logic [NUM_NODES-1:0] s1_vec,
  output logic                 reset_nos,
  output logic [NUM_NODES-1:0] init_state,
  output logic                 start_s0,
  output logic                 start_s1,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_W-1:0]     period,
  output logic [CNT_W-1:0]     transient,
  output logic [NUM_NODES-1:0] attractor
);

`ifdef GRN_TRANSIENT_EN
  localparam state_t PERIOD_NEXT = MU_LOAD;
`else
  localparam state_t PERIOD_NEXT = DONE;
`endif

  state_t               r_state, w_next_state;
  logic [NUM_NODES-1:0] r_init, r_attractor;
  logic [CNT_W-1:0]     r_period;
  logic                 r_timeout;

  logic [CNT_W-1:0] w_step_cnt, w_p_cnt;
  logic             w_step_lim, w_p_lim;
  logic             w_step_clr, w_step_inc, w_p_clr, w_p_inc;
  logic             w_eq, w_run_hit, w_run_adv, w_per_hit, w_per_adv;

  assign w_eq = (s0_vec == s1_vec);
  // After an even number of RUN steps the hare is exactly twice as far as the
  // tortoise, so only even counts are valid Floyd comparison points.
  assign w_run_hit = !w_step_cnt[0] && (w_step_cnt != '0) && w_eq;
  assign w_run_adv = !w_run_hit && !w_step_lim;
  assign w_per_hit = (w_p_cnt != '0) && w_eq;
  assign w_per_adv = !w_per_hit && !w_p_lim;

  grn_step_counter #(.CNT_W(CNT_W), .MAX_STEPS(MAX_STEPS)) u_step_cnt (
    .clk(clk), .rst(rst), .i_clr(w_step_clr), .i_inc(w_step_inc),
    .o_cnt(w_step_cnt), .o_at_limit(w_step_lim)
  );

  grn_step_counter #(.CNT_W(CNT_W), .MAX_STEPS(MAX_STEPS)) u_p_cnt (
    .clk(clk), .rst(rst), .i_clr(w_p_clr), .i_inc(w_p_inc),
    .o_cnt(w_p_cnt), .o_at_limit(w_p_lim)
  );

`ifdef GRN_TRANSIENT_EN
  logic [CNT_W-1:0] w_mu_cnt, r_transient;
  logic             w_mu_lim, w_mu_clr, w_mu_inc, r_phase_b;
  logic             w_adv_done, w_mu_adv_a;

  // MU_ADV reuses the step counter to replay exactly `period` hare moves.
  assign w_adv_done = (w_step_cnt == r_period);
  // Cycle A of a MU step: compare first, then move both if no match.
  assign w_mu_adv_a = !r_phase_b && !w_eq && !w_mu_lim;

  grn_step_counter #(.CNT_W(CNT_W), .MAX_STEPS(MAX_STEPS)) u_mu_cnt (
    .clk(clk), .rst(rst), .i_clr(w_mu_clr), .i_inc(w_mu_inc),
    .o_cnt(w_mu_cnt), .o_at_limit(w_mu_lim)
  );

  assign transient = r_transient;
`else
  assign transient = '0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next_state;
  end

  // Next-state logic.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = LOAD;
      LOAD:    w_next_state = RUN;
      RUN: begin
        if (w_run_hit)       w_next_state = PERIOD;
        else if (w_step_lim) w_next_state = DONE;
      end
      PERIOD: begin
        if (w_per_hit)    w_next_state = PERIOD_NEXT;
        else if (w_p_lim) w_next_state = DONE;
      end
`ifdef GRN_TRANSIENT_EN
      MU_LOAD: w_next_state = MU_ADV;
      MU_ADV:  if (w_adv_done) w_next_state = MU_STEP;
      MU_STEP: if (!r_phase_b && (w_eq || w_mu_lim)) w_next_state = DONE;
`endif
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Output and counter-control logic.
  always_comb begin
    reset_nos  = 1'b0;
    start_s0   = 1'b0;
    start_s1   = 1'b0;
    w_step_clr = 1'b0;
    w_step_inc = 1'b0;
    w_p_clr    = 1'b0;
    w_p_inc    = 1'b0;
`ifdef GRN_TRANSIENT_EN
    w_mu_clr   = 1'b0;
    w_mu_inc   = 1'b0;
`endif
    case (r_state)
      LOAD: begin
        reset_nos  = 1'b1;
        w_step_clr = 1'b1;
        w_p_clr    = 1'b1;
`ifdef GRN_TRANSIENT_EN
        w_mu_clr   = 1'b1;
`endif
      end
      RUN: begin
        start_s0   = w_run_adv;
        start_s1   = w_run_adv;
        w_step_inc = w_run_adv;
      end
      PERIOD: begin
        start_s1 = w_per_adv;
        w_p_inc  = w_per_adv;
      end
`ifdef GRN_TRANSIENT_EN
      MU_LOAD: begin
        reset_nos  = 1'b1;
        w_step_clr = 1'b1;
      end
      MU_ADV: begin
        start_s1   = !w_adv_done;
        w_step_inc = !w_adv_done;
      end
      MU_STEP: begin
        // Cycle B repeats start_s0 so the slow node absorbs its skipped edge
        // and both trajectories end the step one move further on.
        start_s0 = r_phase_b || w_mu_adv_a;
        start_s1 = w_mu_adv_a;
        w_mu_inc = r_phase_b;
      end
`endif
      default: ;
    endcase
  end

  assign busy = (r_state != IDLE) && (r_state != DONE);
  assign done = (r_state == DONE);

  // Captured init vector and results.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_init      <= '0;
      r_attractor <= '0;
      r_period    <= '0;
      r_timeout   <= 1'b0;
`ifdef GRN_TRANSIENT_EN
      r_transient <= '0;
      r_phase_b   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_init      <= init_vec;
            r_attractor <= '0;
            r_period    <= '0;
            r_timeout   <= 1'b0;
`ifdef GRN_TRANSIENT_EN
            r_transient <= '0;
`endif
          end
        end
        RUN: begin
          if (w_run_hit)       r_attractor <= s0_vec;
          else if (w_step_lim) r_timeout   <= 1'b1;
        end
        PERIOD: begin
          if (w_per_hit)    r_period  <= w_p_cnt;
          else if (w_p_lim) r_timeout <= 1'b1;
        end
`ifdef GRN_TRANSIENT_EN
        MU_LOAD: r_phase_b <= 1'b0;
        MU_STEP: begin
          if (r_phase_b)     r_phase_b   <= 1'b0;
          else if (w_eq)     r_transient <= w_mu_cnt;
          else if (w_mu_lim) r_timeout   <= 1'b1;
          else               r_phase_b   <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign init_state = r_init;
  assign attractor  = r_attractor;
  assign period     = r_period;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// -----------------------------------------------------------------------------
// tb_grn_attractor_ctrl
// Directed bench for grn_attractor_ctrl with MAX_STEPS = 8. A small node model
// applies a selectable next-state function f to the two trajectories:
//   mode 0 : identity (fixed point)
//   mode 1 : 11 -> 22 -> 33 -> 11 (pure 3-cycle)
//   mode 2 : 01 -> 02 -> 10 -> 11 -> 12 -> 13 -> 10 (tail 2, cycle 4)
//   mode 3 : x -> (x+1) mod 20 (20-cycle ring)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_grn_attractor_ctrl;

  localparam int N  = 8;
  localparam int CW = 16;

`ifdef GRN_TRANSIENT_EN
  localparam logic [CW-1:0] TAIL_MU = 16'd2;
`else
  localparam logic [CW-1:0] TAIL_MU = 16'd0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [N-1:0]  init_vec;
  logic [N-1:0]  s0_vec, s1_vec;
  logic          reset_nos, start_s0, start_s1, busy, done, timeout;
  logic [N-1:0]  init_state, attractor;
  logic [CW-1:0] period, transient;

  always #5 clk = ~clk;

  grn_attractor_ctrl #(.NUM_NODES(N), .CNT_W(CW), .MAX_STEPS(16'd8)) dut (
    .clk(clk), .rst(rst), .start(start), .init_vec(init_vec),
    .s0_vec(s0_vec), .s1_vec(s1_vec), .reset_nos(reset_nos),
    .init_state(init_state), .start_s0(start_s0), .start_s1(start_s1),
    .busy(busy), .done(done), .timeout(timeout), .period(period),
    .transient(transient), .attractor(attractor)
  );

  // ---------------- node model ----------------
  int           cur_mode = 0;
  logic [N-1:0] m_s0 = '0;
  logic [N-1:0] m_s1 = '0;
  logic         m_tog = 1'b0;

  function automatic logic [N-1:0] f_next(input int mode, input logic [N-1:0] x);
    logic [N-1:0] y;
    y = x;
    case (mode)
      1: case (x)
           8'h11: y = 8'h22;
           8'h22: y = 8'h33;
           8'h33: y = 8'h11;
           default: y = x;
         endcase
      2: case (x)
           8'h01: y = 8'h02;
           8'h02: y = 8'h10;
           8'h10: y = 8'h11;
           8'h11: y = 8'h12;
           8'h12: y = 8'h13;
           8'h13: y = 8'h10;
           default: y = x;
         endcase
      3: y = (x >= 8'd19) ? 8'd0 : x + 8'd1;
      default: y = x;
    endcase
    return y;
  endfunction

  always @(posedge clk) begin
    if (reset_nos) begin
      m_s0  <= init_state;
      m_s1  <= init_state;
      m_tog <= 1'b0;
    end else begin
      if (start_s1) m_s1 <= f_next(cur_mode, m_s1);
      if (start_s0) begin
        if (!m_tog) m_s0 <= f_next(cur_mode, m_s0);
        m_tog <= ~m_tog;
      end
    end
  end

  assign s0_vec = m_s0;
  assign s1_vec = m_s1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " reset_nos"},  32'(reset_nos),  32'd0);
    check({tag, " start_s0"},   32'(start_s0),   32'd0);
    check({tag, " start_s1"},   32'(start_s1),   32'd0);
    check({tag, " busy"},       32'(busy),       32'd0);
    check({tag, " done"},       32'(done),       32'd0);
    check({tag, " timeout"},    32'(timeout),    32'd0);
    check({tag, " period"},     32'(period),     32'd0);
    check({tag, " transient"},  32'(transient),  32'd0);
    check({tag, " attractor"},  32'(attractor),  32'd0);
    check({tag, " init_state"}, 32'(init_state), 32'd0);
  endtask

  typedef struct {
    string         tag;
    int            mode;
    logic [N-1:0]  init;
    int            inject;   // cycle at which a stray start is pulsed, -1 none
    logic [CW-1:0] e_per;
    logic [CW-1:0] e_mu;
    logic [N-1:0]  e_att;
    logic          e_to;
  } vec_t;

  vec_t vecs[5];

  task automatic run_search(input vec_t v);
    int cyc;
    bit seen;
    int extra_done;
    cur_mode = v.mode;
    @(negedge clk);
    init_vec = v.init;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    seen  = 1'b0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        seen = 1'b1;
      end else if (cyc == v.inject) begin
        check({v.tag, " busy at stray start"}, 32'(busy), 32'd1);
        init_vec = 8'hA5;
        start    = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({v.tag, " done seen"},      32'(seen),       32'd1);
    check({v.tag, " busy with done"}, 32'(busy),       32'd0);
    check({v.tag, " period"},         32'(period),     32'(v.e_per));
    check({v.tag, " transient"},      32'(transient),  32'(v.e_mu));
    check({v.tag, " attractor"},      32'(attractor),  32'(v.e_att));
    check({v.tag, " timeout"},        32'(timeout),    32'(v.e_to));
    check({v.tag, " init_state"},     32'(init_state), 32'(v.init));
    extra_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check({v.tag, " single done pulse"}, 32'(extra_done), 32'd0);
    check({v.tag, " idle after done"},   32'(busy),       32'd0);
    check({v.tag, " period held"},       32'(period),     32'(v.e_per));
  endtask

  initial begin
    int  cyc;
    bit  found;
    bit  stray;

    rst      = 1'b0;
    start    = 1'b0;
    init_vec = '0;

    // Reset state, including a start offered while reset is held.
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    start    = 1'b1;
    init_vec = 8'h77;
    @(negedge clk);
    check("start under reset busy", 32'(busy), 32'd0);
    check("start under reset init", 32'(init_state), 32'd0);
    start = 1'b0;
    rst   = 1'b1;
    @(negedge clk);

    vecs[0] = '{"fixed",      0, 8'h5A, -1, 16'd1, 16'd0,   8'h5A, 1'b0};
    vecs[1] = '{"ring3",      1, 8'h11, -1, 16'd3, 16'd0,   8'h11, 1'b0};
    vecs[2] = '{"tail2_cyc4", 2, 8'h01, -1, 16'd4, TAIL_MU, 8'h12, 1'b0};
    vecs[3] = '{"ring20_to",  3, 8'h00, -1, 16'd0, 16'd0,   8'h00, 1'b1};
    vecs[4] = '{"stray_start",2, 8'h01,  3, 16'd4, TAIL_MU, 8'h12, 1'b0};

    foreach (vecs[i]) run_search(vecs[i]);

    // Reset in the middle of the period phase: abandon with no done pulse.
    cur_mode = 1;
    @(negedge clk);
    init_vec = 8'h11;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    stray = 1'b0;
    cyc   = 0;
    while (!found && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) stray = 1'b1;
      if (busy && start_s1 && !start_s0 && !reset_nos) found = 1'b1;
    end
    check("midrst reached PERIOD", 32'(found), 32'd1);
    check("midrst attractor before", 32'(attractor), 32'h11);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) stray = 1'b1;
    end
    check("midrst no done or busy", 32'(stray), 32'd0);

    run_search('{"post_rst", 0, 8'h5A, -1, 16'd1, 16'd0, 8'h5A, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grn_attractor_ctrl.md
GRN_ATTRACTOR_CTRL -- requirements
Module: grn_attractor_ctrl

Interface
REQ-001 SHALL have parameter NUM_NODES, default 8: number of Boolean nodes (state vector width N).
REQ-002 SHALL have parameter CNT_W, default 16: width of the step, period and transient counters.
REQ-003 SHALL have parameter MAX_STEPS, default 16'hFFFF: per-phase step limit before timeout.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: begin a search; sampled in IDLE only.
REQ-007 SHALL have port init_vec, input, N: initial network state, captured when start is accepted.
REQ-008 SHALL have port s0_vec, input, N: concatenated node s0 outputs (slow trajectory).
REQ-009 SHALL have port s1_vec, input, N: concatenated node s1 outputs (fast trajectory).
REQ-010 SHALL have port reset_nos, output, 1: load init_state into all nodes.
REQ-011 SHALL have port init_state, output, N: per-node load value, equal to the captured init_vec.
REQ-012 SHALL have ports start_s0 and start_s1, output, 1 each: node step enables.
REQ-013 SHALL have ports busy, done and timeout, output, 1 each: busy while not IDLE; done is a 1-cycle pulse; timeout is held with the results.
REQ-014 SHALL have ports period and transient, output, CNT_W each, plus attractor, output, N: results, held until the next accepted start.

Function
REQ-015 Node model: s1 advances on every start_s1. s0 advances only on every second start_s0, the first start_s0 after reset_nos included.
REQ-016 The start outputs SHALL be combinational from state, counters and the comparison (eq = s0_vec==s1_vec), so no start is issued in a cycle where a match terminates a phase.
REQ-017 IDLE: on start=1, capture init_vec, clear results and timeout, go to LOAD. Otherwise all node strobes are 0.
REQ-018 LOAD: reset_nos=1 for exactly one cycle, then go to RUN with step_cnt=0.
REQ-019 RUN: each cycle, if step_cnt even, step_cnt>0 and eq, latch attractor=s0_vec and go to PERIOD. Otherwise assert both starts and increment step_cnt.
REQ-020 PERIOD: start_s0=0, with s0 frozen. Each cycle, if p_cnt>0 and eq, period=p_cnt and go to the next phase. Otherwise assert start_s1 and increment p_cnt.
REQ-021 Any counter reaching MAX_STEPS without a match SHALL set timeout=1, pulse done and go to IDLE. Results not yet found stay 0.
REQ-022 DONE: done=1 for one cycle, then go to IDLE. busy drops in the same cycle done pulses.
REQ-023 start while busy SHALL be ignored, with no effect on the search or captured init.
REQ-024 Counters SHALL never wrap; comparisons are unsigned at CNT_W bits.

Reset
REQ-025 While rst=0, at the next edge: state=IDLE; all counters 0; reset_nos, start_s0, start_s1, busy, done and timeout = 0; period, transient, attractor and init_state = 0.
REQ-026 Reset mid-search SHALL abandon the search with no done pulse. The nodes are reloaded by the next LOAD.

Configuration
REQ-027 With macro GRN_TRANSIENT_EN defined, PERIOD SHALL go to MU_LOAD instead of DONE.
REQ-028 MU_LOAD SHALL assert reset_nos for one cycle, then enter MU_ADV.
REQ-029 MU_ADV SHALL assert start_s1 for exactly `period` cycles.
REQ-030 MU_STEP SHALL check eq first. If eq, transient=mu_cnt and go to DONE.
REQ-031 Otherwise MU_STEP SHALL run a 2-cycle step: cycle A asserts both starts, cycle B asserts start_s0 only. mu_cnt then increments.
REQ-032 Without GRN_TRANSIENT_EN, the MU_* states SHALL be absent and transient SHALL be constant 0.

Structure
REQ-033 Package grn_ctrl_pkg SHALL hold the state enum (IDLE, LOAD, RUN, PERIOD, MU_LOAD, MU_ADV, MU_STEP, DONE) and a CNT_W default constant.
REQ-034 Sub-module grn_step_counter (clear, increment, limit flag at MAX_STEPS) SHALL be instantiated for step_cnt, p_cnt and mu_cnt.

Verification
REQ-035 Fixed point, f(x)=x, init 8'h5A: match at step_cnt=2 -> period=1, transient=0, attractor=8'h5A, one done pulse.
REQ-036 Pure 3-cycle ring, init on the cycle: period=3, transient=0, no timeout.
REQ-037 Tail of 2 into a 4-cycle (GRN_TRANSIENT_EN): period=4, transient=2. Without the macro: period=4, transient=0.
REQ-038 MAX_STEPS=8 with a 20-cycle ring -> timeout=1, period=0, done pulse, return to IDLE.
REQ-039 start pulsed during RUN with a different init_vec -> ignored; results match the original init.
REQ-040 rst=0 asserted mid-PERIOD -> all outputs 0 next cycle, no done; a new start completes normally.
